// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, 32-step shift-add multiplier,
// and the EX/MEM pipeline register. ex_stall_o freezes upstream stages during MUL.
`timescale 1ns/1ps
module ex_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            mem_stall_i,
   input  logic [1:0]      ALUOp_i,
   input  logic            ALUSrc_i,
   input  logic            RegWrite_i,
   input  logic            MemWrite_i,
   input  logic            MemRead_i,
   input  logic            MemtoReg_i,
   input  logic [XLEN-1:0] RS1data_i,
   input  logic [XLEN-1:0] RS2data_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [9:0]      funct_i,
   input  logic [4:0]      RDaddr_i,
   input  logic [1:0]      ForwardA_i,
   input  logic [1:0]      ForwardB_i,
   input  logic [XLEN-1:0] MEMdata_i,
   input  logic [XLEN-1:0] WBdata_i,
   output logic [XLEN-1:0] ALUResult_o,
   output logic [XLEN-1:0] MemWdata_o,
   output logic [4:0]      RDaddr_o,
   output logic            RegWrite_o,
   output logic            MemtoReg_o,
   output logic            MemRead_o,
   output logic            MemWrite_o,
   output logic            ex_stall_o
);

   localparam logic [9:0] FunctAnd = 10'b0000000_111;
   localparam logic [9:0] FunctXor = 10'b0000000_100;
   localparam logic [9:0] FunctSll = 10'b0000000_001;
   localparam logic [9:0] FunctAdd = 10'b0000000_000;
   localparam logic [9:0] FunctSub = 10'b0100000_000;
   localparam logic [9:0] FunctMul = 10'b0000001_000;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e          state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic [XLEN-1:0] acc_q, acc_d;

   logic [XLEN-1:0] res_q, res_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [4:0]      rd_q, rd_d;
   logic            regwrite_q, regwrite_d;
   logic            memtoreg_q, memtoreg_d;
   logic            memread_q, memread_d;
   logic            memwrite_q, memwrite_d;

   logic            adv;
   logic            is_mul;
   logic [XLEN-1:0] opa, rs2f, opb, alu_res, acc_step;

   assign adv      = start_i & ~mem_stall_i;
   assign is_mul   = (ALUOp_i == 2'b10) && (funct_i == FunctMul) && RegWrite_i;
   assign opb      = ALUSrc_i ? imm_i : rs2f;
   assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

   // Forwarding muxes for both operands; 00 and 11 both pick register data.
   always_comb begin
      case (ForwardA_i)
         2'b10:   opa = MEMdata_i;
         2'b01:   opa = WBdata_i;
         default: opa = RS1data_i;
      endcase
      case (ForwardB_i)
         2'b10:   rs2f = MEMdata_i;
         2'b01:   rs2f = WBdata_i;
         default: rs2f = RS2data_i;
      endcase
   end

   // Single-cycle ALU; MUL is produced only by the iterative unit, so its code yields 0 here.
   always_comb begin
      alu_res = '0;
      case (ALUOp_i)
         2'b00: alu_res = opa + opb;
         2'b01: alu_res = opa - opb;
         2'b11: begin
            if (funct_i[2:0] == 3'b000) begin
               alu_res = opa + opb;
            end else if (funct_i[2:0] == 3'b101) begin
               alu_res = $unsigned($signed(opa) >>> opb[4:0]);
            end
         end
         default: begin
            case (funct_i)
               FunctAnd: alu_res = opa & opb;
               FunctXor: alu_res = opa ^ opb;
               FunctSll: alu_res = opa << opb[4:0];
               FunctAdd: alu_res = opa + opb;
               FunctSub: alu_res = opa - opb;
               default:  alu_res = '0;
            endcase
         end
      endcase
   end

   // Multiplier FSM next state plus EX/MEM next values; the default load is an all-zero bubble.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      res_d      = '0;
      wdata_d    = '0;
      rd_d       = '0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (is_mul) begin
               state_d  = StBusy;
               mcand_d  = opa;
               mplier_d = opb;
               acc_d    = '0;
               cnt_d    = '0;
            end else begin
               res_d      = alu_res;
               wdata_d    = rs2f;
               rd_d       = RDaddr_i;
               regwrite_d = RegWrite_i;
               memtoreg_d = MemtoReg_i;
               memread_d  = MemRead_i;
               memwrite_d = MemWrite_i;
            end
         end
         StBusy: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = StDone;
            end
         end
         StDone: begin
            // ID/EX still holds the same MUL, so is_mul is not re-evaluated here.
            res_d      = acc_q;
            wdata_d    = rs2f;
            rd_d       = RDaddr_i;
            regwrite_d = RegWrite_i;
            memtoreg_d = MemtoReg_i;
            memread_d  = MemRead_i;
            memwrite_d = MemWrite_i;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Stall is purely a function of FSM state and the current ID/EX entry.
   always_comb begin
      ex_stall_o = ((state_q == StIdle) && is_mul) || (state_q == StBusy);
   end

   // State, multiplier datapath and EX/MEM register; everything holds when not advancing.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         res_q      <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
      end else if (adv) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         res_q      <= res_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
      end
   end

   assign ALUResult_o = res_q;
   assign MemWdata_o  = wdata_q;
   assign RDaddr_o    = rd_q;
   assign RegWrite_o  = regwrite_q;
   assign MemtoReg_o  = memtoreg_q;
   assign MemRead_o   = memread_q;
   assign MemWrite_o  = memwrite_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized ALU traffic
// compared against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_ex_stage;

   localparam logic [9:0] FMul = 10'b0000001_000;

   logic        clk_i = 1'b0;
   logic        rst_i, start_i, mem_stall_i;
   logic [1:0]  ALUOp_i;
   logic        ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i;
   logic [31:0] RS1data_i, RS2data_i, imm_i;
   logic [9:0]  funct_i;
   logic [4:0]  RDaddr_i;
   logic [1:0]  ForwardA_i, ForwardB_i;
   logic [31:0] MEMdata_i, WBdata_i;
   logic [31:0] ALUResult_o, MemWdata_o;
   logic [4:0]  RDaddr_o;
   logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ex_stall_o;

   int n_checks = 0;
   int n_pass   = 0;

   ex_stage #(.XLEN(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mem_stall_i(mem_stall_i),
      .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
      .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .MemtoReg_i(MemtoReg_i),
      .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .imm_i(imm_i), .funct_i(funct_i),
      .RDaddr_i(RDaddr_i), .ForwardA_i(ForwardA_i), .ForwardB_i(ForwardB_i),
      .MEMdata_i(MEMdata_i), .WBdata_i(WBdata_i), .ALUResult_o(ALUResult_o),
      .MemWdata_o(MemWdata_o), .RDaddr_o(RDaddr_o), .RegWrite_o(RegWrite_o),
      .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
      .ex_stall_o(ex_stall_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: operand selection as described for the stage.
   function automatic logic [31:0] fwd_model(input logic [31:0] r, input logic [1:0] sel,
                                             input logic [31:0] m, input logic [31:0] w);
      if (sel == 2'b10) return m;
      if (sel == 2'b01) return w;
      return r;
   endfunction

   // Reference: ALU result from the operation table using plain arithmetic.
   function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [9:0] f,
                                             input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      sa = a;
      if (op == 2'b00) return a + b;
      if (op == 2'b01) return a - b;
      if (op == 2'b11) begin
         if (f[2:0] == 3'b000) return a + b;
         if (f[2:0] == 3'b101) return sa >>> b[4:0];
         return 32'd0;
      end
      if (f == 10'b0000000_111) return a & b;
      if (f == 10'b0000000_100) return a ^ b;
      if (f == 10'b0000000_001) return a << b[4:0];
      if (f == 10'b0000000_000) return a + b;
      if (f == 10'b0100000_000) return a - b;
      if (f == FMul)            return a * b;
      return 32'd0;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      start_i = 1'b1; mem_stall_i = 1'b0;
      ALUOp_i = 2'b00; ALUSrc_i = 1'b0; RegWrite_i = 1'b0; MemWrite_i = 1'b0;
      MemRead_i = 1'b0; MemtoReg_i = 1'b0; RS1data_i = '0; RS2data_i = '0; imm_i = '0;
      funct_i = '0; RDaddr_i = '0; ForwardA_i = 2'b00; ForwardB_i = 2'b00;
      MEMdata_i = '0; WBdata_i = '0;
   endtask

   // Drives one MUL (a * b, register operands) and follows it to completion, optionally
   // holding mem_stall_i for stall_len cycles starting stall_at cycles after issue.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int stall_at,
                          input int stall_len, input string name);
      int          stall_cycles;
      int          rw_high;
      int          end_c;
      logic [31:0] exp_p;
      exp_p = a * b;
      end_c = 34 + stall_len;
      stall_cycles = 0;
      rw_high = 0;
      clear_inputs();
      ALUOp_i = 2'b10; funct_i = FMul; RegWrite_i = 1'b1; RS1data_i = a; RS2data_i = b;
      RDaddr_i = 5'd9;
      for (int c = 0; c < end_c; c++) begin
         mem_stall_i = (c >= stall_at) && (c < stall_at + stall_len);
         #1;
         if (ex_stall_o) stall_cycles++;
         if (c > 0 && RegWrite_o) rw_high++;
         tick();
      end
      mem_stall_i = 1'b0;
      n_checks++;
      if (ALUResult_o !== exp_p)
         $display("FAIL %s product: got %h want %h", name, ALUResult_o, exp_p);
      else n_pass++;
      n_checks++;
      if ({RegWrite_o, RDaddr_o, MemWdata_o} !== {1'b1, 5'd9, b})
         $display("FAIL %s writeback: got %b/%0d/%h want 1/9/%h", name, RegWrite_o,
                  RDaddr_o, MemWdata_o, b);
      else n_pass++;
      n_checks++;
      if (stall_cycles !== 33 + stall_len)
         $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cycles,
                  33 + stall_len);
      else n_pass++;
      n_checks++;
      if (rw_high !== 0)
         $display("FAIL %s bubble_regwrite: got %0d high cycles want 0", name, rw_high);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_i = 1'b1;
      ALUOp_i = 2'b00; RegWrite_i = 1'b1; RS1data_i = 32'h11; imm_i = 32'h22; ALUSrc_i = 1'b1;
      RDaddr_i = 5'd3;
      tick();
      tick();
      n_checks++;
      if ({ALUResult_o, MemWdata_o} !== 64'd0)
         $display("FAIL reset_data: got %h %h want 0 0", ALUResult_o, MemWdata_o);
      else n_pass++;
      n_checks++;
      if ({RDaddr_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} !== 9'd0)
         $display("FAIL reset_ctrl: got %0d %b%b%b%b want 0 0000", RDaddr_o, RegWrite_o,
                  MemtoReg_o, MemRead_o, MemWrite_o);
      else n_pass++;
      n_checks++;
      if (ex_stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", ex_stall_o);
      else n_pass++;
      rst_i = 1'b0;
      tick();
      n_checks++;
      if ({ALUResult_o, RDaddr_o, RegWrite_o} !== {32'h33, 5'd3, 1'b1})
         $display("FAIL reset_first_op: got %h %0d %b want 00000033 3 1", ALUResult_o,
                  RDaddr_o, RegWrite_o);
      else n_pass++;
   endtask

   task automatic test_add_forward();
      clear_inputs();
      ALUOp_i = 2'b10; funct_i = 10'd0; RS1data_i = 32'd5; ForwardA_i = 2'b10;
      MEMdata_i = 32'd7; RS2data_i = 32'd3; RegWrite_i = 1'b1; RDaddr_i = 5'd4;
      tick();
      n_checks++;
      if (ALUResult_o !== 32'd10) $display("FAIL add_fwd: got %h want 0000000a", ALUResult_o);
      else n_pass++;
      n_checks++;
      if (RegWrite_o !== 1'b1) $display("FAIL add_fwd_rw: got %b want 1", RegWrite_o);
      else n_pass++;
      RegWrite_i = 1'b0;
      tick();
      n_checks++;
      if (RegWrite_o !== 1'b0) $display("FAIL add_fwd_rw0: got %b want 0", RegWrite_o);
      else n_pass++;
   endtask

   task automatic test_srai_sub();
      clear_inputs();
      ALUOp_i = 2'b11; funct_i = 10'b0100000_101; ALUSrc_i = 1'b1;
      RS1data_i = 32'h8000_0000; imm_i = 32'd4; RegWrite_i = 1'b1;
      tick();
      n_checks++;
      if (ALUResult_o !== 32'hF800_0000)
         $display("FAIL srai: got %h want f8000000", ALUResult_o);
      else n_pass++;
      clear_inputs();
      ALUOp_i = 2'b10; funct_i = 10'b0100000_000; RS1data_i = 32'd3; RS2data_i = 32'd5;
      RegWrite_i = 1'b1;
      tick();
      n_checks++;
      if (ALUResult_o !== 32'hFFFF_FFFE)
         $display("FAIL sub: got %h want fffffffe", ALUResult_o);
      else n_pass++;
   endtask

   task automatic test_store();
      clear_inputs();
      ALUOp_i = 2'b00; ALUSrc_i = 1'b1; RS1data_i = 32'h100; imm_i = 32'd8;
      ForwardB_i = 2'b01; WBdata_i = 32'hDEAD_BEEF; RS2data_i = 32'h1234; MemWrite_i = 1'b1;
      tick();
      n_checks++;
      if ({ALUResult_o, MemWdata_o, MemWrite_o, RegWrite_o} !== {32'h108, 32'hDEAD_BEEF, 2'b10})
         $display("FAIL store: got %h %h we=%b rw=%b want 00000108 deadbeef 1 0",
                  ALUResult_o, MemWdata_o, MemWrite_o, RegWrite_o);
      else n_pass++;
   endtask

   task automatic test_hold();
      clear_inputs();
      ALUOp_i = 2'b00; RS1data_i = 32'd40; RS2data_i = 32'd2; RegWrite_i = 1'b1;
      tick();
      ALUOp_i = 2'b01; mem_stall_i = 1'b1;
      tick();
      n_checks++;
      if (ALUResult_o !== 32'd42) $display("FAIL hold_mem_stall: got %h want 0000002a",
                                           ALUResult_o);
      else n_pass++;
      mem_stall_i = 1'b0; start_i = 1'b0;
      tick();
      n_checks++;
      if (ALUResult_o !== 32'd42) $display("FAIL hold_start: got %h want 0000002a",
                                           ALUResult_o);
      else n_pass++;
      start_i = 1'b1;
      tick();
      n_checks++;
      if (ALUResult_o !== 32'd38) $display("FAIL hold_release: got %h want 00000026",
                                           ALUResult_o);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [9:0]  ftab [5];
      logic [31:0] a, b, rs2f, exp_res;
      logic [43:0] exp_side;
      ftab[0] = 10'b0000000_111; ftab[1] = 10'b0000000_100; ftab[2] = 10'b0000000_001;
      ftab[3] = 10'b0000000_000; ftab[4] = 10'b0100000_000;
      for (int i = 0; i < 40; i++) begin
         clear_inputs();
         ALUOp_i = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) funct_i = 10'($urandom_range(0, 1023));
         else if (ALUOp_i == 2'b11) funct_i = ($urandom_range(0, 1) == 1) ? 10'b0100000_101
                                                                        : 10'b0000000_000;
         else funct_i = ftab[$urandom_range(0, 4)];
         if (funct_i == FMul) funct_i = 10'h3FF;
         ALUSrc_i = 1'($urandom_range(0, 1));
         RegWrite_i = 1'($urandom_range(0, 1)); MemWrite_i = 1'($urandom_range(0, 1));
         MemRead_i = 1'($urandom_range(0, 1)); MemtoReg_i = 1'($urandom_range(0, 1));
         RS1data_i = $urandom; RS2data_i = $urandom; imm_i = $urandom;
         MEMdata_i = $urandom; WBdata_i = $urandom; RDaddr_i = 5'($urandom_range(0, 31));
         ForwardA_i = 2'($urandom_range(0, 3)); ForwardB_i = 2'($urandom_range(0, 3));
         a = fwd_model(RS1data_i, ForwardA_i, MEMdata_i, WBdata_i);
         rs2f = fwd_model(RS2data_i, ForwardB_i, MEMdata_i, WBdata_i);
         b = ALUSrc_i ? imm_i : rs2f;
         exp_res = alu_model(ALUOp_i, funct_i, a, b);
         exp_side = {rs2f, RDaddr_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, 3'b000};
         #1;
         n_checks++;
         if (ex_stall_o !== 1'b0) $display("FAIL b2b_stall[%0d]: got %b want 0", i, ex_stall_o);
         else n_pass++;
         tick();
         n_checks++;
         if (ALUResult_o !== exp_res)
            $display("FAIL b2b_result[%0d]: op=%b f=%b got %h want %h", i, ALUOp_i, funct_i,
                     ALUResult_o, exp_res);
         else n_pass++;
         n_checks++;
         if ({MemWdata_o, RDaddr_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, 3'b000}
             !== exp_side)
            $display("FAIL b2b_side[%0d]: got %h want %h", i,
                     {MemWdata_o, RDaddr_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
                      3'b000}, exp_side);
         else n_pass++;
      end
   endtask

   task automatic test_mul_latency();
      run_mul(32'hFFFF_FFFF, 32'd7, 0, 0, "mul_latency");
   endtask

   task automatic test_mul_mem_stall();
      run_mul(32'd12345, 32'd678, 5, 3, "mul_mem_stall");
   endtask

   task automatic test_reset_mid_mul();
      clear_inputs();
      ALUOp_i = 2'b10; funct_i = FMul; RegWrite_i = 1'b1; RS1data_i = 32'h1234;
      RS2data_i = 32'h55; RDaddr_i = 5'd7;
      for (int c = 0; c < 10; c++) tick();
      rst_i = 1'b1;
      #1;
      n_checks++;
      if ({ALUResult_o, MemWdata_o, RDaddr_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}
          !== 73'd0)
         $display("FAIL rst_mid_mul_outputs: got %h %h %0d %b%b%b%b want all 0", ALUResult_o,
                  MemWdata_o, RDaddr_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o);
      else n_pass++;
      clear_inputs();
      #1;
      n_checks++;
      if (ex_stall_o !== 1'b0) $display("FAIL rst_mid_mul_stall: got %b want 0", ex_stall_o);
      else n_pass++;
      tick();
      rst_i = 1'b0;
      ALUOp_i = 2'b00; RS1data_i = 32'd100; RS2data_i = 32'd23; RegWrite_i = 1'b1;
      #1;
      n_checks++;
      if (ex_stall_o !== 1'b0) $display("FAIL rst_release_stall: got %b want 0", ex_stall_o);
      else n_pass++;
      tick();
      n_checks++;
      if (ALUResult_o !== 32'd123) $display("FAIL rst_release_add: got %h want 0000007b",
                                            ALUResult_o);
      else n_pass++;
      run_mul(32'd3, 32'd5, 0, 0, "mul_after_reset");
   endtask

   initial begin
      rst_i = 1'b1;
      clear_inputs();
      test_reset();
      test_add_forward();
      test_srai_sub();
      test_store();
      test_hold();
      test_back_to_back();
      test_mul_latency();
      test_mul_mem_stall();
      test_reset_mid_mul();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
